// File: rtl/spi_shifter_pkg.sv
// Shared SPI definitions: shifter state encoding, default word length and
// the baud-rate generator settings that pair with the shifter.
package spi_shifter_pkg;

    localparam int SPI_DATA_W_DEF = 8;

    // Legacy-compatible state constants for the shift engine
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Baud-rate generator settings; sclk_en/sample form the handshake
    localparam int BAUD_DIV_W   = 12;
    localparam int BAUD_DIV_MIN = 2;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    typedef struct packed {
        logic [BAUD_DIV_W-1:0] div;
        spi_mode_e             mode;
    } baud_cfg_t;

    // Clamp a requested divider so SCLK never runs faster than clk/2.
    function automatic logic [BAUD_DIV_W-1:0] baud_div_clamp(
        input logic [BAUD_DIV_W-1:0] div
    );
        if (div < BAUD_DIV_W'(BAUD_DIV_MIN)) begin
            return BAUD_DIV_W'(BAUD_DIV_MIN);
        end
        return div;
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// SPI master shift engine: serialises one DATA_W word on mosi while
// assembling the received word from miso, one bit per sample pulse.
module spi_shifter
    import spi_shifter_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              lsbfe,
    input  logic              sample,
    input  logic              miso,
    output logic              sclk_en,
    output logic              mosi,
    output logic              ss_n,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [0:0]        state_q,   state_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic              lsbfe_q,   lsbfe_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic              ss_n_q,    ss_n_d;
    logic              sclk_en_q, sclk_en_d;
    logic              done_q,    done_d;
    logic [DATA_W-1:0] rx_q,      rx_d;
    logic [DATA_W-1:0] shifted;

    // Shift toward the output end; miso fills the bit that was vacated.
    always_comb begin
        if (lsbfe_q) begin
            shifted = {miso, shreg_q[DATA_W-1:1]};
        end else begin
            shifted = {shreg_q[DATA_W-2:0], miso};
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        lsbfe_d   = lsbfe_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        ss_n_d    = ss_n_q;
        sclk_en_d = sclk_en_q;
        rx_d      = rx_q;
        done_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d   = ST_XFER;
                shreg_d   = tx_data;
                lsbfe_d   = lsbfe;
                cnt_d     = '0;
                busy_d    = 1'b1;
                ss_n_d    = 1'b0;
                sclk_en_d = 1'b1;
            end
        end else if (sample) begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
            // Final bit: publish the word and release the bus on this edge
            if (cnt_q == CNT_LAST) begin
                state_d   = ST_IDLE;
                rx_d      = shifted;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                ss_n_d    = 1'b1;
                sclk_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            lsbfe_q   <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            sclk_en_q <= 1'b0;
            done_q    <= 1'b0;
            rx_q      <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            lsbfe_q   <= lsbfe_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            ss_n_q    <= ss_n_d;
            sclk_en_q <= sclk_en_d;
            done_q    <= done_d;
            rx_q      <= rx_d;
        end
    end

    assign mosi    = lsbfe_q ? shreg_q[0] : shreg_q[DATA_W-1];
    assign sclk_en = sclk_en_q;
    assign ss_n    = ss_n_q;
    assign busy    = busy_q;
    assign rx_data = rx_q;
    assign done    = done_q;

endmodule
